// File: rtl/instr_fetch_stage_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// instr_fetch_stage_if : fetch-stage control, IMEM and IF/ID bundle
// Rev 1.0
// ----------------------------------------------------------------------------
interface instr_fetch_stage_if #(
  parameter int ADDR_WIDTH = 8
) ();
  logic                  i_stall;
  logic                  i_branch_taken;
  logic [ADDR_WIDTH-1:0] i_branch_target;
  logic [ADDR_WIDTH-1:0] o_imem_addr;
  logic [23:0]           i_imem_rdata;
  logic [23:0]           o_if_id_instr;
  logic [ADDR_WIDTH-1:0] o_if_id_pc;
  logic                  o_if_id_valid;
  logic [3:0]            o_opcode;

  modport slave (
    input  i_stall, i_branch_taken, i_branch_target, i_imem_rdata,
    output o_imem_addr, o_if_id_instr, o_if_id_pc, o_if_id_valid, o_opcode
  );

  modport master (
    output i_stall, i_branch_taken, i_branch_target, i_imem_rdata,
    input  o_imem_addr, o_if_id_instr, o_if_id_pc, o_if_id_valid, o_opcode
  );
endinterface
`default_nettype wire

// File: rtl/instr_fetch_stage.sv
`default_nettype none
// ----------------------------------------------------------------------------
// instr_fetch_stage : PC, 1-cycle IMEM fetch, IF/ID register with skid buffer
// Rev 1.0
// ----------------------------------------------------------------------------
module instr_fetch_stage #(
  parameter int                    ADDR_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                clk,
  input  logic                rst,
  instr_fetch_stage_if.slave  bus
);

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  state_t                r_state,      w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_pc,         w_pc_nxt;
  logic                  r_pend_valid, w_pend_valid_nxt;
  logic [ADDR_WIDTH-1:0] r_pend_pc,    w_pend_pc_nxt;
  logic [23:0]           r_skid,       w_skid_nxt;
  logic [ADDR_WIDTH-1:0] r_skid_pc,    w_skid_pc_nxt;
  logic [23:0]           r_instr,      w_instr_nxt;
  logic [ADDR_WIDTH-1:0] r_ifid_pc,    w_ifid_pc_nxt;
  logic                  r_ifid_valid, w_ifid_valid_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_RUN;
      r_pc         <= RESET_PC;
      r_pend_valid <= 1'b0;
      r_pend_pc    <= '0;
      r_skid       <= '0;
      r_skid_pc    <= '0;
      r_instr      <= '0;
      r_ifid_pc    <= '0;
      r_ifid_valid <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_pend_valid <= w_pend_valid_nxt;
      r_pend_pc    <= w_pend_pc_nxt;
      r_skid       <= w_skid_nxt;
      r_skid_pc    <= w_skid_pc_nxt;
      r_instr      <= w_instr_nxt;
      r_ifid_pc    <= w_ifid_pc_nxt;
      r_ifid_valid <= w_ifid_valid_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_pc_nxt         = r_pc;
    w_pend_valid_nxt = r_pend_valid;
    w_pend_pc_nxt    = r_pend_pc;
    w_skid_nxt       = r_skid;
    w_skid_pc_nxt    = r_skid_pc;
    w_instr_nxt      = r_instr;
    w_ifid_pc_nxt    = r_ifid_pc;
    w_ifid_valid_nxt = r_ifid_valid;

    if (bus.i_branch_taken) begin
      // Redirect drops both the word in flight and any skid entry.
      w_pc_nxt         = bus.i_branch_target;
      w_pend_valid_nxt = 1'b0;
      w_ifid_valid_nxt = 1'b0;
      w_state_nxt      = ST_RUN;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (!bus.i_stall) begin
            w_instr_nxt      = bus.i_imem_rdata;
            w_ifid_pc_nxt    = r_pend_pc;
            w_ifid_valid_nxt = r_pend_valid;
            w_pend_pc_nxt    = r_pc;
            w_pend_valid_nxt = 1'b1;
            w_pc_nxt         = r_pc + 1'b1;
          end else begin
            // The word landing now would be lost; park it. The read of PC
            // issued on this edge is discarded and reissued on release.
            w_skid_nxt       = bus.i_imem_rdata;
            w_skid_pc_nxt    = r_pend_pc;
            w_pend_valid_nxt = 1'b0;
            if (r_pend_valid) begin
              w_state_nxt = ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (!bus.i_stall) begin
            w_instr_nxt      = r_skid;
            w_ifid_pc_nxt    = r_skid_pc;
            w_ifid_valid_nxt = 1'b1;
            w_pend_pc_nxt    = r_pc;
            w_pend_valid_nxt = 1'b1;
            w_pc_nxt         = r_pc + 1'b1;
            w_state_nxt      = ST_RUN;
          end
        end
        default: begin
          w_state_nxt = ST_RUN;
        end
      endcase
    end
  end

  assign bus.o_imem_addr   = r_pc;
  assign bus.o_if_id_instr = r_instr;
  assign bus.o_if_id_pc    = r_ifid_pc;
  assign bus.o_if_id_valid = r_ifid_valid;
  assign bus.o_opcode      = r_ifid_valid ? r_instr[23:20] : 4'b0000;

endmodule
`default_nettype wire

// File: doc/instr_fetch_stage.md
# instr_fetch_stage

Instruction fetch stage of the 24-bit CPU. It holds the program counter and addresses a synchronous-read instruction memory with one cycle of read latency. It registers each fetched word into the IF/ID pipeline register and supplies the 4-bit opcode field to the control unit downstream. Stall is handled with a one-entry skid buffer, so no fetched word is lost. A taken branch redirects the PC and flushes in-flight fetches.

## Interface
- ADDR_WIDTH, 8, instruction-memory word-address width; also the PC width.
- RESET_PC, 0, PC value loaded on reset.
- Clock  in  1  system clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-high reset.
- Stall  in  1  hold IF/ID and PC; asserted by the hazard logic.
- BranchTaken  in  1  redirect request; one-cycle pulse.
- BranchTarget  in  ADDR_WIDTH  redirect word address; sampled when BranchTaken=1.
- IMEM_ADDR  out  ADDR_WIDTH  instruction-memory address; equals the PC register.
- IMEM_RDATA  in  24  memory word for the address presented on the previous edge.
- IF_ID_Instr  out  24  registered instruction.
- IF_ID_PC  out  ADDR_WIDTH  word address of IF_ID_Instr.
- IF_ID_Valid  out  1  IF/ID holds a real instruction.
- OPCODE  out  4  IF_ID_Instr[23:20] when IF_ID_Valid=1, else 4'b0000.

## Operation
- Internal registers:
  - PC
  - PendValid / PendPC: describe the word arriving on IMEM_RDATA this cycle.
  - Skid / SkidPC: skid buffer.
  - State: RUN or HOLD.
- Reset:
  - PC=RESET_PC, PendValid=0, PendPC=0, State=RUN.
  - IF_ID_Valid=0, IF_ID_Instr=0, IF_ID_PC=0, so OPCODE=0000.
  - Skid and SkidPC are cleared to 0.
- Priority per edge is Reset > BranchTaken > Stall > normal.
- BranchTaken=1, in any state and regardless of Stall:
  - PC<=BranchTarget, PendValid<=0, IF_ID_Valid<=0, State<=RUN.
  - IF_ID_Instr and IF_ID_PC are held.
- RUN, Stall=0:
  - IF_ID_Instr<=IMEM_RDATA, IF_ID_PC<=PendPC, IF_ID_Valid<=PendValid.
  - PendPC<=PC, PendValid<=1, PC<=PC+1.
- RUN, Stall=1:
  - IF/ID and PC hold.
  - Skid<=IMEM_RDATA, SkidPC<=PendPC. HOLD is entered only when PendValid=1; otherwise State stays RUN.
  - PendValid<=0.
- HOLD, Stall=1: everything holds; memory keeps reading PC.
- HOLD, Stall=0:
  - IF_ID_Instr<=Skid, IF_ID_PC<=SkidPC, IF_ID_Valid<=1.
  - PendPC<=PC, PendValid<=1, PC<=PC+1, State<=RUN.
- PC arithmetic is modulo 2^ADDR_WIDTH; PC=all-ones increments to 0 with no flag.
- A flushed or bubble IF/ID entry presents OPCODE 4'b0000, which decodes as no instruction (no register or memory write).
- Only OPCODE is gated. IF_ID_Instr keeps its last value when invalid.

## Timing
- IMEM_ADDR is combinational from PC. Memory data returns on the following cycle.
- After Reset falls, the first edge issues RESET_PC. The second edge loads IF_ID with mem[RESET_PC] and IF_ID_Valid=1. After that, one instruction per cycle in sequential flow.
- Branch penalty is 2 bubble cycles:
  - Edge E (BranchTaken=1): IF_ID_Valid=0.
  - Edge E+1: issues the target.
  - Edge E+2: IF_ID holds mem[target] with IF_ID_Valid=1.
- Stall of N cycles followed by release:
  - The IF/ID contents are held for the N cycles.
  - The instruction fetched behind it is delivered from the skid buffer on the release edge.
  - Sequence continuity is preserved, with no duplicate or missing PC.
- Reset asserted mid-stall or mid-branch discards all pending and skid contents on that edge.
- Stall and BranchTaken high on the same edge: the branch wins and the stall has no effect on that edge.

## Test plan
- Reset release, memory word at address n = n, Stall=0:
  - IF_ID_PC reads 0,1,2,3 on consecutive edges starting at the 2nd edge after release.
  - OPCODE=0000 before the first valid entry.
- Branch at IF_ID_PC=5 with BranchTarget=8'h40:
  - Two cycles of IF_ID_Valid=0 / OPCODE=0000.
  - Then IF_ID_PC=0x40, 0x41.
- Stall held 3 cycles while IF_ID_PC=3:
  - IF_ID_PC stays 3 for all 3 cycles.
  - After release, IF_ID_PC=4, then 5; no skip, no repeat.
- Stall and BranchTaken together with target 0x10, while HOLD has a skid entry:
  - Skid is discarded.
  - Two bubbles, then IF_ID_PC=0x10.
- PC wrap with ADDR_WIDTH=8 and Reset to RESET_PC=0xFE: IF_ID_PC sequence is FE, FF, 00, 01.
- Reset asserted for one edge during HOLD:
  - On the next edge IF_ID_Valid=0, OPCODE=0000, State=RUN.
  - Refetch begins at RESET_PC.
